elevator_motion_fsm: RTL
========================

Name: elevator_motion_fsm

Overview:
- Car-side motion/door controller for the 4-floor elevator; the opposite end of the request/stop handshake served by the memory manager.
- Consumes OCRequest, UDRequest and NoStopRequest, and produces CurrentFloor, UDIn, Delay (arrived at floor) and Stop (idle at floor).
- Models floor-to-floor travel and door dwell with tick counters and drives the motor and door outputs.

Parameters:
TRAVEL_TICKS, 50, clk cycles to travel between adjacent floors (>=2)
DOOR_TICKS, 100, clk cycles the door stays open (>=2)
ACK_TIMEOUT, 255, clk cycles to wait in ARRIVE for DoneDelay before declaring fault (>=2)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
OCRequest  in  1  open-door request from manager
UDRequest  in  1  direction request, 1=up 0=down
NoStopRequest  in  1  1 = manager has pending stops, leave idle
DoneDelay  in  1  manager has processed the current arrival
CurrentFloor  out  2  floor the car is at or last passed, 0..3
UDIn  out  1  latched travel direction, 1=up
Delay  out  1  arrival-at-floor strobe, held until acknowledged
Stop  out  1  car idle at floor, doors closed
DoorOpen  out  1  door actuator
MotorUp  out  1  motor drive up
MotorDown  out  1  motor drive down
Fault  out  1  sticky ack-timeout flag

Behaviour:
- One clock; reset is asynchronous and active-low (rst_n). All state and outputs are registered.
- Reset values: state=IDLE, CurrentFloor=0, UDIn=0, Delay=0, Stop=1, DoorOpen=0, MotorUp=0, MotorDown=0, Fault=0, all counters 0.
- Reset asserted mid-operation returns to these values immediately. The car is treated as at floor 0, with no recovery of its previous position.
- oc_rise = OCRequest & ~oc_q; dd_rise = DoneDelay & ~dd_q. oc_q and dd_q are registered copies of the inputs and reset to 0.
- legal(dir): dir=1 requires CurrentFloor<3; dir=0 requires CurrentFloor>0.
- States:
- IDLE: Stop=1, motors 0, DoorOpen=0.
  - oc_rise -> DOOR. This has priority.
  - Else NoStopRequest=1 and legal(UDRequest) -> RUN: UDIn<=UDRequest, Stop<=0, travel counter<=0.
  - Else NoStopRequest=1 with an illegal direction: stay in IDLE, no output change.
  - OCRequest held high from before IDLE entry does not reopen the door; only a rising edge does.
- RUN: MotorUp=UDIn, MotorDown=~UDIn, Stop=0. The counter increments each cycle. On the cycle count==TRAVEL_TICKS-1:
  - CurrentFloor <= CurrentFloor+1 if UDIn, else -1.
  - Delay<=1, motors<=0, ack counter<=0, go to ARRIVE.
  - The floor never wraps; legal() guarantees this.
- ARRIVE: Delay=1, motors 0. Ack counter increments. dd_rise is the acknowledge, and OCRequest/UDRequest are sampled in that same cycle.
  - On dd_rise: Delay<=0, then branch:
    - OCRequest=1 -> DOOR.
    - Else legal(UDRequest) and NoStopRequest=1 -> RUN with UDIn<=UDRequest.
    - Else legal(UDIn) and NoStopRequest=1 -> RUN with UDIn unchanged.
    - Else -> IDLE.
  - Ack counter reaches ACK_TIMEOUT-1 without dd_rise: Fault<=1 (sticky until reset), Delay<=0, go to IDLE.
  - dd_rise and timeout in the same cycle: the acknowledge wins and Fault stays unchanged.
  - DoneDelay already high on ARRIVE entry is not an acknowledge.
- DOOR: DoorOpen=1, Stop=0, motors 0. The door counter runs 0..DOOR_TICKS-1, then DoorOpen<=0 and go to IDLE.
  - oc_rise while in DOOR restarts the door counter at 0.
- Motors are never both 1. DoorOpen and any motor are never both 1. Delay=1 only in ARRIVE.
- Latency: NoStopRequest to MotorUp/MotorDown = 1 cycle. RUN entry to Delay = TRAVEL_TICKS cycles. dd_rise to next state = 1 cycle.

Test Plan:
- Reset, then NoStopRequest=1, UDRequest=1 at floor 0 -> MotorUp=1 next cycle. After TRAVEL_TICKS: CurrentFloor=1, Delay=1, MotorUp=0.
- In ARRIVE at floor 1, pulse DoneDelay with OCRequest=1 -> Delay=0 and DoorOpen=1 for DOOR_TICKS cycles, then Stop=1. OCRequest held high through IDLE entry does not reopen the door.
- Car at floor 3, UDRequest=1, NoStopRequest=1 -> stays IDLE, Stop=1, motors 0. Then UDRequest=0 -> MotorDown=1, and CurrentFloor=2 after TRAVEL_TICKS.
- DoneDelay tied high entering ARRIVE -> no acknowledge; after ACK_TIMEOUT cycles Fault=1, Delay=0, Stop=1. Fault stays 1 until rst_n pulse.
- Assert rst_n=0 mid-RUN at floor 2 -> outputs go to reset values asynchronously, CurrentFloor=0, Stop=1, no clock edge needed.
- Ack with OCRequest=0, NoStopRequest=1, UDRequest=1 at floor 1 -> continues to floor 2 without the door opening, Delay raised again after TRAVEL_TICKS.

Source files
------------

// File: rtl/elevator_motion_fsm.sv
// elevator_motion_fsm: car motion/door controller with travel, door-dwell and arrival-ack timeout counters
module elevator_motion_fsm #(
  parameter int TRAVEL_TICKS = 50,
  parameter int DOOR_TICKS = 100,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       OCRequest,
  input  logic       UDRequest,
  input  logic       NoStopRequest,
  input  logic       DoneDelay,
  output logic [1:0] CurrentFloor,
  output logic       UDIn,
  output logic       Delay,
  output logic       Stop,
  output logic       DoorOpen,
  output logic       MotorUp,
  output logic       MotorDown,
  output logic       Fault
);
  localparam int MX01 = TRAVEL_TICKS > DOOR_TICKS ? TRAVEL_TICKS : DOOR_TICKS;
  localparam int MX = MX01 > ACK_TIMEOUT ? MX01 : ACK_TIMEOUT;
  localparam int CW = $clog2(MX);
  typedef enum logic [1:0] {IDLE, RUN, ARRIVE, DOOR} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0] floor_n;
  logic ud_n, delay_n, stop_n, door_n, up_n, dn_n, fault_n;
  logic oc_q, dd_q, oc_rise, dd_rise, req_ok, cur_ok;
  function automatic logic legal(input logic d, input logic [1:0] f);
    return d ? (f != 2'd3) : (f != 2'd0);
  endfunction
  assign oc_rise = OCRequest & ~oc_q;
  assign dd_rise = DoneDelay & ~dd_q;
  assign req_ok = legal(UDRequest, CurrentFloor);
  assign cur_ok = legal(UDIn, CurrentFloor);
  always_comb begin
    state_n = state;
    cnt_n = cnt + 1'b1;
    floor_n = CurrentFloor;
    ud_n = UDIn;
    delay_n = Delay;
    stop_n = Stop;
    door_n = DoorOpen;
    up_n = MotorUp;
    dn_n = MotorDown;
    fault_n = Fault;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (oc_rise) begin
          state_n = DOOR;
          stop_n = 1'b0;
          door_n = 1'b1;
        end else if (NoStopRequest && req_ok) begin
          state_n = RUN;
          ud_n = UDRequest;
          stop_n = 1'b0;
          up_n = UDRequest;
          dn_n = ~UDRequest;
        end
      end
      RUN: if (cnt == CW'(TRAVEL_TICKS - 1)) begin
        state_n = ARRIVE;
        floor_n = UDIn ? CurrentFloor + 2'd1 : CurrentFloor - 2'd1;
        delay_n = 1'b1;
        up_n = 1'b0;
        dn_n = 1'b0;
        cnt_n = '0;
      end
      // an acknowledge landing on the timeout cycle still wins
      ARRIVE: if (dd_rise) begin
        delay_n = 1'b0;
        cnt_n = '0;
        if (OCRequest) begin
          state_n = DOOR;
          door_n = 1'b1;
        end else if (NoStopRequest && (req_ok || cur_ok)) begin
          state_n = RUN;
          ud_n = req_ok ? UDRequest : UDIn;
          up_n = ud_n;
          dn_n = ~ud_n;
        end else begin
          state_n = IDLE;
          stop_n = 1'b1;
        end
      end else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
        state_n = IDLE;
        fault_n = 1'b1;
        delay_n = 1'b0;
        stop_n = 1'b1;
      end
      DOOR: if (oc_rise) cnt_n = '0;
        else if (cnt == CW'(DOOR_TICKS - 1)) begin
          state_n = IDLE;
          door_n = 1'b0;
          stop_n = 1'b1;
        end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      CurrentFloor <= 2'd0;
      UDIn <= 1'b0;
      Delay <= 1'b0;
      Stop <= 1'b1;
      DoorOpen <= 1'b0;
      MotorUp <= 1'b0;
      MotorDown <= 1'b0;
      Fault <= 1'b0;
      oc_q <= 1'b0;
      dd_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      CurrentFloor <= floor_n;
      UDIn <= ud_n;
      Delay <= delay_n;
      Stop <= stop_n;
      DoorOpen <= door_n;
      MotorUp <= up_n;
      MotorDown <= dn_n;
      Fault <= fault_n;
      oc_q <= OCRequest;
      dd_q <= DoneDelay;
    end
endmodule
